// File: rtl/edge_mask_pkg.sv
// Shared constants and state encoding for the edge-mask transmit slice.
// The only supported geometry is 128 x 32-bit words = 32 x 128-bit slices.
package edge_mask_pkg;

    localparam int WORD_W  = 32;
    localparam int NWORDS  = 128;
    localparam int SLICE_W = 128;
    localparam int NSLICE  = 32;
    localparam int XYZ_W   = 14;
    localparam int FRAME_W = WORD_W * NWORDS;
    localparam int CNT_W   = $clog2(NWORDS);
    localparam int SEL_W   = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARM,
        STREAM
    } state_t;

endpackage

// File: rtl/edge_mask_slice_sel.sv
// Combinational 4096->128 slice mux; slice k is frame bits [4095-128k : 3968-128k],
// so index 0 picks the top four words (127..124).
module edge_mask_slice_sel
    import edge_mask_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    input  logic [SEL_W-1:0]   idx,
    output logic [SLICE_W-1:0] slice
);

    always_comb begin
        slice = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx == SEL_W'(k)) begin
                slice = frame[(NSLICE-1-k)*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: rtl/edge_mask_tx.sv
// Edge-mask transmitter: loads a 4096-bit frame from the host, then streams it as
// 32 slices locked to the receiver's data_sel sweep. Optional EDGE_MASK_TX_REPEAT_EN
// makes the frame retransmit every sweep until abort or a new start.
module edge_mask_tx
    import edge_mask_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               start,
    input  logic [XYZ_W-1:0]   xyz_in,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               abort,
    input  logic [SEL_W-1:0]   data_sel,
    output logic [SLICE_W-1:0] edge_mask,
    output logic [XYZ_W-1:0]   xyz_out,
    output logic               busy,
    output logic               done,
    output logic               sync_err
);

`ifdef EDGE_MASK_TX_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NSLICE - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [SLICE_W-1:0]   edge_mask_q, edge_mask_d;
    logic [XYZ_W-1:0]     xyz_q, xyz_d;
    logic                 done_q, done_d;
    logic                 sync_err_q, sync_err_d;
    logic [SEL_W-1:0]     prev_sel_q;
    logic [SLICE_W-1:0]   next_slice;
    logic                 wr_fire, sel_ok, kill, restart;

    // The register is loaded one slice ahead so it already holds slice k while data_sel==k.
    edge_mask_slice_sel u_slice_sel (
        .frame (frame_q),
        .idx   (data_sel + SEL_W'(1)),
        .slice (next_slice)
    );

    assign wr_fire = (state_q == LOAD) && wr_valid;
    assign sel_ok  = (data_sel == prev_sel_q + SEL_W'(1));
    assign kill    = abort && (state_q != IDLE);
    assign restart = REPEAT_EN && start && (state_q == STREAM) && sel_ok;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            edge_mask_q <= '0;
            xyz_q       <= '0;
            done_q      <= 1'b0;
            sync_err_q  <= 1'b0;
            prev_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            edge_mask_q <= edge_mask_d;
            xyz_q       <= xyz_d;
            done_q      <= done_d;
            sync_err_q  <= sync_err_d;
            prev_sel_q  <= data_sel;
        end
    end

    always_ff @(posedge CLK) begin
        frame_q <= frame_d;
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (start) state_d = LOAD;
                LOAD:   if (wr_fire && cnt_q == LAST_WORD) state_d = ARM;
                ARM:    if (data_sel == LAST_SEL) state_d = STREAM;
                STREAM: begin
                    if (!sel_ok)                    state_d = IDLE;
                    else if (restart)               state_d = LOAD;
                    else if (data_sel == LAST_SEL)  state_d = REPEAT_EN ? STREAM : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        edge_mask_d = '0;
        xyz_d       = xyz_q;
        done_d      = 1'b0;
        sync_err_d  = sync_err_q;
        if (kill) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xyz_d = xyz_in;
                        cnt_d = '0;
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        for (int w = 0; w < NWORDS; w++) begin
                            if (cnt_q == CNT_W'(w)) frame_d[w*WORD_W +: WORD_W] = wr_data;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ARM: begin
                    if (data_sel == LAST_SEL) edge_mask_d = next_slice;
                end
                STREAM: begin
                    if (!sel_ok) begin
                        sync_err_d = 1'b1;
                    end else if (restart) begin
                        xyz_d = xyz_in;
                        cnt_d = '0;
                    end else begin
                        done_d      = (data_sel == LAST_SEL);
                        edge_mask_d = (data_sel == LAST_SEL && !REPEAT_EN) ? '0 : next_slice;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign edge_mask = edge_mask_q;
    assign xyz_out   = xyz_q;
    assign done      = done_q;
    assign sync_err  = sync_err_q;

endmodule
